rv_hazard_ctrl: RTL
===================

// Module: rv_hazard_ctrl
// PURPOSE
//  Hazard/forwarding scheduler for the 5-stage pipeline. Keeps shadow copies of the ID/EX,
//  EX/MEM and MEM/WB destination info. Drives the EX-stage operand-forwarding selects,
//  load-use stalls, branch flushes and whole-pipeline freezes on data-memory wait.
//  Sits beside the ID/EX/MEM stages; all of its outputs feed pipeline-register enables and flushes.
// PARAMETERS
//  RA_W       5   register-address width
//  CNT_W      32  perf-counter width (used only with RV_HAZARD_PERF_EN)
//  MWAIT_MAX  15  max consecutive mem-wait cycles before timeout flag
// PORTS
//  i_hz_clk          in   1      clock
//  i_hz_rst          in   1      reset; synchronous, active-high
//  i_hz_id_rs1       in   RA_W   rs1 of instruction in ID
//  i_hz_id_rs2       in   RA_W   rs2 of instruction in ID
//  i_hz_id_rs1_en    in   1      ID instruction reads rs1
//  i_hz_id_rs2_en    in   1      ID instruction reads rs2
//  i_hz_id_rd        in   RA_W   rd of ID instruction
//  i_hz_id_rf_we     in   1      ID instruction writes rd
//  i_hz_id_is_load   in   1      ID instruction is a load
//  i_hz_ex_br_taken  in   1      EX redirect (taken branch/jal/jalr)
//  i_hz_mem_busy     in   1      data memory not ready this cycle
//  o_hz_stall_if     out  1      hold PC
//  o_hz_stall_id     out  1      hold IF/ID register
//  o_hz_stall_exmem  out  1      hold ID/EX, EX/MEM and MEM/WB registers
//  o_hz_flush_ifid   out  1      clear IF/ID to bubble
//  o_hz_flush_idex   out  1      clear ID/EX to bubble
//  o_hz_rd1_sel      out  2      EX rs1 mux: 00 regfile, 01 MEM fwd, 10 WB fwd
//  o_hz_rd2_sel      out  2      EX rs2 mux: same encoding
//  o_hz_mem_timeout  out  1      sticky: mem wait exceeded MWAIT_MAX
//  o_hz_stall_cnt    out  CNT_W  load-use + mem-wait stall cycles
//  o_hz_flush_cnt    out  CNT_W  branch flush events
// BEHAVIOUR
//  - Shadows: EX{rs1,rs2,rd,we,ld}, MEM{rd,we,ld}, WB{rd,we}. Bubble = all fields 0.
//  - Reset: shadows = bubble; state RUN; timeout, counters and wait counter = 0.
//    All outputs read 0 in the cycle after reset.
//  - Hit(X,r) = X.we & X.rd!=0 & X.rd==r. A write to x0 never forwards or stalls.
//  - rdN_sel (comb.): 01 if Hit(MEM,EX.rsN) & !MEM.ld; else 10 if Hit(WB,EX.rsN); else 00.
//    MEM has priority over WB.
//  - LU (comb.) = EX.ld & ((rs1_en & Hit(EX,id_rs1)) | (rs2_en & Hit(EX,id_rs2))).
//  - Priority each cycle: FREEZE (mem_busy) > FLUSH (br_taken) > LU > none.
//    FREEZE: stall_if=stall_id=stall_exmem=1; flush=0; shadows hold.
//    FLUSH:  flush_ifid=flush_idex=1; stalls=0; EX shadow <= bubble.
//    LU:     stall_if=stall_id=flush_idex=1; EX shadow <= bubble. Stall lasts exactly 1 cycle.
//    none:   EX <= ID inputs.
//  - Shadow advance when not frozen: MEM <= EX, WB <= MEM. Updates land on the same edge
//    as the pipeline registers.
//  - br_taken together with mem_busy: freeze wins. EX is held, so br_taken re-presents
//    after the wait and the flush occurs then.
//  - FSM: RUN -> MWAIT when mem_busy=1; MWAIT stays while mem_busy=1; MWAIT -> RUN when mem_busy=0.
//    The RUN-return cycle is handled as a normal RUN cycle.
//    Wait counter: +1 per busy cycle, cleared in RUN, saturates at MWAIT_MAX+1.
//    When the counter would exceed MWAIT_MAX, o_hz_mem_timeout <= 1; it stays set until reset.
//  - Reset mid-MWAIT: immediate return to reset state; a pending flush is dropped.
// CONFIGURATION
//  RV_HAZARD_PERF_EN defined:
//    stall_cnt +1 on each cycle with LU or FREEZE; flush_cnt +1 on each FLUSH cycle.
//    Both wrap modulo 2^CNT_W and are cleared by reset.
//  Undefined: counter ports tied to 0, no counter flops.
// TESTING
//  1. add x5; add x6,x5,x1 back-to-back -> rd1_sel=01 in consumer EX; one-gap consumer -> rd1_sel=10.
//  2. lw x6; add x7,x1,x6 -> 1 cycle stall_if=stall_id=flush_idex=1, then rd2_sel=10, no further stall.
//  3. LU hit and br_taken in the same cycle -> flush_ifid=flush_idex=1, stall_if=0,
//     flush_cnt +1, stall_cnt unchanged.
//  4. mem_busy 3 cycles, MWAIT_MAX=2 -> stall_* high 3 cycles, sel stable, timeout=1 after 3rd cycle.
//  5. addi x0 followed by a reader of x0 -> sels stay 00, no stall.
//  6. Reset asserted during MWAIT with br_taken=1 -> next cycle all outputs 0, state RUN.

Source files
------------

// File: rtl/rv_hazard_ctrl_if.sv
// Hazard-controller bus: ID/EX/MEM status in from the pipeline, stall/flush/forward controls out.
interface rv_hazard_ctrl_if #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
);
  logic [RA_W-1:0]  i_hz_id_rs1;
  logic [RA_W-1:0]  i_hz_id_rs2;
  logic             i_hz_id_rs1_en;
  logic             i_hz_id_rs2_en;
  logic [RA_W-1:0]  i_hz_id_rd;
  logic             i_hz_id_rf_we;
  logic             i_hz_id_is_load;
  logic             i_hz_ex_br_taken;
  logic             i_hz_mem_busy;
  logic             o_hz_stall_if;
  logic             o_hz_stall_id;
  logic             o_hz_stall_exmem;
  logic             o_hz_flush_ifid;
  logic             o_hz_flush_idex;
  logic [1:0]       o_hz_rd1_sel;
  logic [1:0]       o_hz_rd2_sel;
  logic             o_hz_mem_timeout;
  logic [CNT_W-1:0] o_hz_stall_cnt;
  logic [CNT_W-1:0] o_hz_flush_cnt;

  modport master (
    output i_hz_id_rs1, i_hz_id_rs2, i_hz_id_rs1_en, i_hz_id_rs2_en, i_hz_id_rd,
           i_hz_id_rf_we, i_hz_id_is_load, i_hz_ex_br_taken, i_hz_mem_busy,
    input  o_hz_stall_if, o_hz_stall_id, o_hz_stall_exmem, o_hz_flush_ifid,
           o_hz_flush_idex, o_hz_rd1_sel, o_hz_rd2_sel, o_hz_mem_timeout,
           o_hz_stall_cnt, o_hz_flush_cnt
  );

  modport slave (
    input  i_hz_id_rs1, i_hz_id_rs2, i_hz_id_rs1_en, i_hz_id_rs2_en, i_hz_id_rd,
           i_hz_id_rf_we, i_hz_id_is_load, i_hz_ex_br_taken, i_hz_mem_busy,
    output o_hz_stall_if, o_hz_stall_id, o_hz_stall_exmem, o_hz_flush_ifid,
           o_hz_flush_idex, o_hz_rd1_sel, o_hz_rd2_sel, o_hz_mem_timeout,
           o_hz_stall_cnt, o_hz_flush_cnt
  );
endinterface

// File: rtl/rv_hazard_ctrl.sv
// 5-stage pipeline hazard/forwarding scheduler with mem-wait freeze and timeout.
// Optional perf counters enabled by defining RV_HAZARD_PERF_EN.
module rv_hazard_ctrl #(
  parameter int RA_W      = 5,
  parameter int CNT_W     = 32,
  parameter int MWAIT_MAX = 15
) (
  input  logic            i_hz_clk,
  input  logic            i_hz_rst,
  rv_hazard_ctrl_if.slave hz
);
  typedef struct packed {
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic            we;
    logic            ld;
  } ex_sh_t;

  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic            we;
    logic            ld;
  } mem_sh_t;

  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic            we;
  } wb_sh_t;

  typedef enum logic {RUN, MWAIT} state_t;

  localparam int              WC_W = $clog2(MWAIT_MAX + 2);
  localparam logic [WC_W-1:0] WMAX = WC_W'(MWAIT_MAX);

  ex_sh_t          ex_q;
  mem_sh_t         mem_q;
  wb_sh_t          wb_q;
  state_t          state_q, state_d;
  logic [WC_W-1:0] wcnt_q;
  logic            tmo_q;
  logic            lu, freeze, flush, lu_stall;

  function automatic logic hit(input logic we, input logic [RA_W-1:0] rd, input logic [RA_W-1:0] r);
    return we && (rd != '0) && (rd == r);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] r, input mem_sh_t m, input wb_sh_t w);
    if (hit(m.we, m.rd, r) && !m.ld) return 2'b01;
    if (hit(w.we, w.rd, r))          return 2'b10;
    return 2'b00;
  endfunction

  assign lu = ex_q.ld &&
              ((hz.i_hz_id_rs1_en && hit(ex_q.we, ex_q.rd, hz.i_hz_id_rs1)) ||
               (hz.i_hz_id_rs2_en && hit(ex_q.we, ex_q.rd, hz.i_hz_id_rs2)));

  // Freeze comes straight from mem_busy so the first busy cycle already holds the pipe.
  always_comb begin
    state_d  = state_q;
    freeze   = 1'b0;
    flush    = 1'b0;
    lu_stall = 1'b0;
    case (state_q)
      RUN:     if (hz.i_hz_mem_busy)  state_d = MWAIT;
      MWAIT:   if (!hz.i_hz_mem_busy) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (hz.i_hz_mem_busy)         freeze   = 1'b1;
    else if (hz.i_hz_ex_br_taken) flush    = 1'b1;
    else if (lu)                  lu_stall = 1'b1;
  end

  always_comb begin
    hz.o_hz_stall_if    = freeze | lu_stall;
    hz.o_hz_stall_id    = freeze | lu_stall;
    hz.o_hz_stall_exmem = freeze;
    hz.o_hz_flush_ifid  = flush;
    hz.o_hz_flush_idex  = flush | lu_stall;
    hz.o_hz_rd1_sel     = fwd_sel(ex_q.rs1, mem_q, wb_q);
    hz.o_hz_rd2_sel     = fwd_sel(ex_q.rs2, mem_q, wb_q);
    hz.o_hz_mem_timeout = tmo_q;
  end

  always_ff @(posedge i_hz_clk) begin
    if (i_hz_rst) begin
      state_q <= RUN;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      wcnt_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (freeze) begin
        if (wcnt_q <= WMAX) wcnt_q <= wcnt_q + 1'b1;
        if (wcnt_q >= WMAX) tmo_q  <= 1'b1;
      end else begin
        wcnt_q <= '0;
        wb_q   <= '{rd: mem_q.rd, we: mem_q.we};
        mem_q  <= '{rd: ex_q.rd, we: ex_q.we, ld: ex_q.ld};
        if (flush || lu_stall) ex_q <= '0;
        else ex_q <= '{rs1: hz.i_hz_id_rs1, rs2: hz.i_hz_id_rs2, rd: hz.i_hz_id_rd,
                       we: hz.i_hz_id_rf_we, ld: hz.i_hz_id_is_load};
      end
    end
  end

`ifdef RV_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge i_hz_clk) begin
    if (i_hz_rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (freeze || lu_stall) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush)              flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign hz.o_hz_stall_cnt = stall_cnt_q;
  assign hz.o_hz_flush_cnt = flush_cnt_q;
`else
  assign hz.o_hz_stall_cnt = '0;
  assign hz.o_hz_flush_cnt = '0;
`endif
endmodule
